drive_cmd_framer: RTL

- Upstream stage of the PWM drive block: turns a byte stream from the host link receiver into the 16-bit drive command {direction, speed} that the PWM block consumes on its `data_in`.
- Validates each frame with a sync byte and a checksum, and holds the last good command.
- A watchdog forces a safe command (neutral steering, zero speed) if the host goes silent.

---
 rtl/drive_cmd_framer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/drive_cmd_framer.sv
// rtl/drive_cmd_framer.sv - host byte stream to {direction, speed} drive command framer
module drive_cmd_framer #(
  parameter int unsigned TIMEOUT_CYCLES  = 5_000_000,
  parameter int unsigned BYTE_GAP_CYCLES = 100_000,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5,
  parameter logic [7:0]  SAFE_DIR        = 8'h80,
  parameter logic [7:0]  SAFE_SPD        = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] cmd_out,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic        timeout
);

  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(BYTE_GAP_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP_CYCLES - 1);
  localparam logic [15:0]      SAFE_CMD = {SAFE_DIR, SAFE_SPD};

  typedef enum logic [1:0] {IDLE, GET_DIR, GET_SPD, GET_CSUM} state_e;

  state_e             state_q, state_d;
  logic [7:0]         dir_q, dir_d;
  logic [7:0]         spd_q, spd_d;
  logic [15:0]        cmd_q, cmd_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               timeout_q, timeout_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic in_frame;
  logic csum_byte;
  logic accept;
  logic gap_exp;
  logic wd_exp;

  // Event decode shared by the next-state and output logic
  always_comb begin
    in_frame  = (state_q != IDLE);
    csum_byte = (state_q == GET_CSUM) && rx_valid;
    accept    = csum_byte && (rx_data == (dir_q ^ spd_q));
    // A byte arriving on the expiry cycle is processed instead of the gap error
    gap_exp   = in_frame && !rx_valid && (gap_q == GAP_LAST);
    // An accepted frame on the expiry cycle takes precedence over the safe command
    wd_exp    = !accept && (wd_q == WD_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: advance one field per byte, abandon a frame on gap expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rx_valid && (rx_data == SYNC_BYTE)) state_d = GET_DIR;
      GET_DIR:  if (rx_valid) state_d = GET_SPD;  else if (gap_exp) state_d = IDLE;
      GET_SPD:  if (rx_valid) state_d = GET_CSUM; else if (gap_exp) state_d = IDLE;
      GET_CSUM: if (rx_valid || gap_exp) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output/datapath next values: field latches, command update, error pulses, counters
  always_comb begin
    dir_d       = dir_q;
    spd_d       = spd_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    frame_err_d = gap_exp || (csum_byte && !accept);
    timeout_d   = timeout_q;

    if ((state_q == GET_DIR) && rx_valid) dir_d = rx_data;
    if ((state_q == GET_SPD) && rx_valid) spd_d = rx_data;

    if (wd_exp) begin
      cmd_d     = SAFE_CMD;
      timeout_d = 1'b1;
    end
    if (accept) begin
      cmd_d       = {dir_q, spd_q};
      cmd_valid_d = 1'b1;
      timeout_d   = 1'b0;
    end

    if (accept)              wd_d = '0;
    else if (wd_q == WD_MAX) wd_d = wd_q;
    else                     wd_d = wd_q + WD_W'(1);

    // Gap count only runs while a frame is partially received
    if (rx_valid || !in_frame || gap_exp) gap_d = '0;
    else                                  gap_d = gap_q + GAP_W'(1);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      dir_q       <= 8'h00;
      spd_q       <= 8'h00;
      cmd_q       <= SAFE_CMD;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      wd_q        <= '0;
      gap_q       <= '0;
    end else begin
      dir_q       <= dir_d;
      spd_q       <= spd_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
    end
  end

  assign cmd_out   = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign timeout   = timeout_q;

endmodule
